// File: rtl/round_robin_encoder_if.sv
// rtl/round_robin_encoder_if.sv - request/grant bundle for the round-robin encoder (iLock present under ROUND_ROBIN_ENCODER_LOCK_EN)
interface round_robin_encoder_if #(
  parameter int WIDTH = 5
);
  localparam int N = 2 ** WIDTH;

  logic [N-1:0]     iReq;
  logic             iAck;
`ifdef ROUND_ROBIN_ENCODER_LOCK_EN
  logic             iLock;
`endif
  logic             oValid;
  logic [WIDTH-1:0] oIndex;

`ifdef ROUND_ROBIN_ENCODER_LOCK_EN
  modport master (output iReq, output iAck, output iLock, input oValid, input oIndex);
  modport slave  (input iReq, input iAck, input iLock, output oValid, output oIndex);
`else
  modport master (output iReq, output iAck, input oValid, input oIndex);
  modport slave  (input iReq, input iAck, output oValid, output oIndex);
`endif
endinterface

// File: rtl/round_robin_encoder.sv
// rtl/round_robin_encoder.sv - round-robin arbiter emitting a registered binary grant index; ROUND_ROBIN_ENCODER_LOCK_EN adds burst lock
module round_robin_encoder #(
  parameter int WIDTH = 5
) (
  input  logic                  iClk,
  input  logic                  iRst_n,
  round_robin_encoder_if.slave  bus
);
  localparam int N = 2 ** WIDTH;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state, nextState;
  logic [WIDTH-1:0] ptr, nextPtr;
  logic [WIDTH-1:0] index, nextIndex;
  logic [WIDTH-1:0] arbBase, arbIndex, scan;
  logic [N-1:0]     cand, ownMask;
  logic             arbFound, accept;

  // While granting, the arbiter already looks past the current owner so an ack can hand over without a bubble.
  assign ownMask = {{(N-1){1'b0}}, 1'b1} << index;
  assign arbBase = (state == GRANT) ? index + 1'b1 : ptr;
  assign cand    = (state == GRANT) ? (bus.iReq & ~ownMask) : bus.iReq;

`ifdef ROUND_ROBIN_ENCODER_LOCK_EN
  assign accept = bus.iAck & ~bus.iLock;
`else
  assign accept = bus.iAck;
`endif

  always_comb begin : arbiter
    arbFound = 1'b0;
    arbIndex = '0;
    scan     = '0;
    for (int i = 0; i < N; i++) begin
      scan = arbBase + i[WIDTH-1:0];
      if (!arbFound && cand[scan]) begin
        arbFound = 1'b1;
        arbIndex = scan;
      end
    end
  end

  always_comb begin : nextLogic
    nextState = state;
    nextPtr   = ptr;
    nextIndex = index;
    case (state)
      IDLE: begin
        if (arbFound) begin
          nextState = GRANT;
          nextIndex = arbIndex;
        end
      end
      GRANT: begin
        if (accept) begin
          nextPtr = arbBase;
          if (arbFound) begin
            nextIndex = arbIndex;
          end else begin
            nextState = IDLE;
          end
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state <= IDLE;
      ptr   <= '0;
      index <= '0;
    end else begin
      state <= nextState;
      ptr   <= nextPtr;
      index <= nextIndex;
    end
  end

  assign bus.oValid = (state == GRANT);
  assign bus.oIndex = index;
endmodule

// File: tb/tb_round_robin_encoder.sv
// tb/tb_round_robin_encoder.sv - scoreboard bench for round_robin_encoder; lock cases built with ROUND_ROBIN_ENCODER_LOCK_EN
module tb_round_robin_encoder;
  localparam int W = 5;
  localparam int N = 2 ** W;

  typedef struct {
    string        name;
    logic         valid;
    logic [W-1:0] index;
  } exp_t;

  logic clk;
  logic rstN;
  int   checks;
  int   errors;
  exp_t expQ[$];

  round_robin_encoder_if #(.WIDTH(W)) bus ();

  round_robin_encoder #(.WIDTH(W)) dut (
    .iClk   (clk),
    .iRst_n (rstN),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue the outputs expected right after the edge.
  task automatic step(input string name, input logic [N-1:0] req, input logic ack,
                      input logic rstn, input logic expValid, input int expIndex);
    exp_t e;
    bus.iReq = req;
    bus.iAck = ack;
    rstN     = rstn;
    @(posedge clk);
    e.name  = name;
    e.valid = expValid;
    e.index = expIndex[W-1:0];
    expQ.push_back(e);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checks++;
      if (bus.oValid !== e.valid || bus.oIndex !== e.index) begin
        errors++;
        $display("FAIL %s: got valid=%0b index=%0d, expected valid=%0b index=%0d",
                 e.name, bus.oValid, bus.oIndex, e.valid, e.index);
      end
    end
  end

  initial begin
    logic [N-1:0] allOnes;
    checks  = 0;
    errors  = 0;
    allOnes = '1;
    bus.iReq = '0;
    bus.iAck = 1'b0;
    rstN     = 1'b0;
`ifdef ROUND_ROBIN_ENCODER_LOCK_EN
    bus.iLock = 1'b0;
`endif
    #2;

    step("reset0", '0, 1'b1, 1'b0, 1'b0, 0);
    step("reset1", allOnes, 1'b1, 1'b0, 1'b0, 0);

    // single requester, release, pointer moves to 1
    step("first_grant", 32'h0000_0001, 1'b0, 1'b1, 1'b1, 0);
    step("ack_to_idle", '0, 1'b1, 1'b1, 1'b0, 0);
    step("idle_hold", '0, 1'b0, 1'b1, 1'b0, 0);
    step("ptr_is_1", 32'h0000_0003, 1'b0, 1'b1, 1'b1, 1);
    step("ack_to_idle2", '0, 1'b1, 1'b1, 1'b0, 1);

    // full rotation with continuous acks
    step("reset_rot", '0, 1'b0, 1'b0, 1'b0, 0);
    step("rot_start", allOnes, 1'b0, 1'b1, 1'b1, 0);
    for (int k = 1; k <= N; k++) step("rotation", allOnes, 1'b1, 1'b1, 1'b1, k % N);
    step("rot_end", '0, 1'b1, 1'b1, 1'b0, 0);

    // pointer to 30 then wrap-around search
    step("grant29", 32'h2000_0000, 1'b0, 1'b1, 1'b1, 29);
    step("release29", '0, 1'b1, 1'b1, 1'b0, 29);
    step("wrap_grant0", 32'h0000_0005, 1'b0, 1'b1, 1'b1, 0);
    step("then_grant2", 32'h0000_0005, 1'b1, 1'b1, 1'b1, 2);
    step("then_idle", '0, 1'b1, 1'b1, 1'b0, 2);

    // no preemption while waiting for ack
    step("grant7", 32'h0000_0080, 1'b0, 1'b1, 1'b1, 7);
    for (int k = 0; k < 10; k++) step("hold7", '0, 1'b0, 1'b1, 1'b1, 7);
    step("release7", '0, 1'b1, 1'b1, 1'b0, 7);

    // reset mid-grant beats ack, pointer restarts at 0
    step("grant12", 32'h0000_1000, 1'b0, 1'b1, 1'b1, 12);
    step("reset_mid", 32'h0000_3000, 1'b1, 1'b0, 1'b0, 0);
    step("ptr_after_rst", 32'h0010_0020, 1'b0, 1'b1, 1'b1, 5);
    step("release5", '0, 1'b1, 1'b1, 1'b0, 5);

    // top index, then wrap from N-1 to 0 on ack
    step("grant31", 32'h8000_0008, 1'b0, 1'b1, 1'b1, 31);
    step("wrap_to_3", 32'h8000_0008, 1'b1, 1'b1, 1'b1, 3);
    step("release3", '0, 1'b1, 1'b1, 1'b0, 3);

    // ack while idle leaves the pointer at 4
    step("idle_ack", '0, 1'b1, 1'b1, 1'b0, 3);
    step("ptr_still_4", 32'h0000_0030, 1'b0, 1'b1, 1'b1, 4);
    step("release4", '0, 1'b1, 1'b1, 1'b0, 4);

`ifdef ROUND_ROBIN_ENCODER_LOCK_EN
    step("lock_reset", '0, 1'b0, 1'b0, 1'b0, 0);
    step("lock_grant4", 32'h0000_0010, 1'b0, 1'b1, 1'b1, 4);
    bus.iLock = 1'b1;
    for (int k = 0; k < 3; k++) step("locked4", 32'h0000_0110, 1'b1, 1'b1, 1'b1, 4);
    bus.iLock = 1'b0;
    step("unlock_to_8", 32'h0000_0110, 1'b1, 1'b1, 1'b1, 8);
    step("lock_release", '0, 1'b1, 1'b1, 1'b0, 8);
`endif

    @(negedge clk);
    #1;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", expQ.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
